// File: rtl/qs_insts_pkg.sv
// Shared microcode ISA types: PC, instruction word, opcode/cc encodings,
// and the fetch-sequencer state enum.
package qs_insts_pkg;

    typedef logic [7:0] pc_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_PUSH = 4'h1,
        OP_POP  = 4'h2,
        OP_LD   = 4'h3,
        OP_ST   = 4'h4,
        OP_MOV  = 4'h5,
        OP_MOVI = 4'h6,
        OP_MOVS = 4'h7,
        OP_ADD  = 4'h8,
        OP_SUB  = 4'h9,
        OP_J    = 4'hA,
        OP_CALL = 4'hB,
        OP_RET  = 4'hC,
        OP_WAIT = 4'hD,
        OP_EMIT = 4'hE
    } op_t;

    typedef enum logic [1:0] {
        CC_AL = 2'b00,
        CC_EQ = 2'b01,
        CC_GT = 2'b10,
        CC_LE = 2'b11
    } cc_t;

    typedef struct packed {
        op_t        op;
        cc_t        cc;
        logic [1:0] rsv;
        pc_t        a;
    } inst_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLAGS = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } fetch_state_t;

    function automatic pc_t pc_inc(input pc_t p);
        return p + 8'd1;
    endfunction

endpackage

// File: rtl/qs_ucode_fetch_dec.sv
// Combinational field extraction and classification of the fetched word.
// Opcodes outside the defined set classify as NOP.
module qs_ucode_fetch_dec
    import qs_insts_pkg::*;
(
    input  inst_t inst,
    input  logic  flag_eq,
    input  logic  flag_gt,
    output logic  is_issue,
    output logic  is_jmp,
    output logic  is_cond,
    output logic  taken,
    output logic  is_call,
    output logic  is_ret,
    output logic  is_wait,
    output logic  is_emit,
    output pc_t   target
);

    logic unused_rsv;
    assign unused_rsv = ^inst.rsv;
    assign target     = inst.a;

    always_comb begin
        is_issue = 1'b0;
        is_jmp   = 1'b0;
        is_call  = 1'b0;
        is_ret   = 1'b0;
        is_wait  = 1'b0;
        is_emit  = 1'b0;
        case (inst.op)
            OP_PUSH, OP_POP, OP_LD, OP_ST, OP_MOV,
            OP_MOVI, OP_MOVS, OP_ADD, OP_SUB: is_issue = 1'b1;
            OP_J:    is_jmp  = 1'b1;
            OP_CALL: is_call = 1'b1;
            OP_RET:  is_ret  = 1'b1;
            OP_WAIT: is_wait = 1'b1;
            OP_EMIT: is_emit = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        is_cond = (inst.cc != CC_AL);
        case (inst.cc)
            CC_AL:   taken = 1'b1;
            CC_EQ:   taken = flag_eq;
            CC_GT:   taken = flag_gt;
            CC_LE:   taken = !flag_gt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/qs_ucode_fetch.sv
// Microcode fetch sequencer. Optional stall counter enabled by
// defining QS_UCODE_FETCH_PERF_EN.
module qs_ucode_fetch
    import qs_insts_pkg::*;
#(
    parameter logic RET_ON_RST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output pc_t         ra,
    input  inst_t       rin,
    output logic        issue_vld,
    output inst_t       issue_inst,
    output pc_t         issue_pc,
    input  logic        issue_ack,
    input  logic        flags_vld,
    input  logic        flag_eq,
    input  logic        flag_gt,
    output logic        blink_wr_en,
    output pc_t         blink_wr_data,
    input  pc_t         blink_rd_data,
    input  logic        queue_ready,
    output logic        emit_req,
    input  logic        emit_ack,
`ifdef QS_UCODE_FETCH_PERF_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        busy
);

    fetch_state_t state, state_n;
    pc_t          pc, pc_n, pc_nxt, target;
    logic         first;
    logic         is_issue, is_jmp, is_cond, taken;
    logic         is_call, is_ret, is_wait, is_emit;
    logic         call_wr;

    qs_ucode_fetch_dec u_dec (
        .inst     (rin),
        .flag_eq  (flag_eq),
        .flag_gt  (flag_gt),
        .is_issue (is_issue),
        .is_jmp   (is_jmp),
        .is_cond  (is_cond),
        .taken    (taken),
        .is_call  (is_call),
        .is_ret   (is_ret),
        .is_wait  (is_wait),
        .is_emit  (is_emit),
        .target   (target)
    );

    assign pc_nxt = pc_inc(pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            pc    <= '0;
            first <= 1'b1;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            first <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        case (state)
            S_RUN: begin
                if (is_issue) begin
                    if (issue_ack) pc_n = pc_nxt;
                end else if (is_jmp) begin
                    if (!is_cond || flags_vld)
                        pc_n = taken ? target : pc_nxt;
                    else
                        state_n = S_FLAGS;
                end else if (is_call) begin
                    pc_n = target;
                end else if (is_ret) begin
                    pc_n = blink_rd_data;
                end else if (is_wait) begin
                    state_n = S_WAIT;
                end else if (is_emit) begin
                    state_n = S_EMIT;
                end else begin
                    pc_n = pc_nxt;
                end
            end
            S_FLAGS: if (flags_vld) begin
                pc_n    = taken ? target : pc_nxt;
                state_n = S_RUN;
            end
            S_WAIT: if (queue_ready) begin
                pc_n    = pc_nxt;
                state_n = S_RUN;
            end
            S_EMIT: if (emit_ack) begin
                pc_n    = pc_nxt;
                state_n = S_RUN;
            end
            default: state_n = S_RUN;
        endcase
    end

    // Gate on rst so outputs drop while reset is held, not just at release.
    always_comb begin
        ra            = pc;
        issue_inst    = rin;
        issue_pc      = pc;
        issue_vld     = !rst && (state == S_RUN) && is_issue;
        emit_req      = !rst && (state == S_EMIT);
        call_wr       = !rst && (state == S_RUN) && is_call;
        blink_wr_en   = call_wr || (RET_ON_RST && first && !rst);
        blink_wr_data = call_wr ? pc_nxt : '0;
        busy          = (state != S_WAIT);
    end

`ifdef QS_UCODE_FETCH_PERF_EN
    logic stall;
    assign stall = (state == S_FLAGS) || (state == S_EMIT)
                || (issue_vld && !issue_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_qs_ucode_fetch.sv
// Directed bench for qs_ucode_fetch: ROM and link register modelled here,
// expected values hand-computed from the program loaded below.
module tb_qs_ucode_fetch;
    import qs_insts_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    pc_t   ra;
    inst_t rin;
    logic  issue_vld;
    inst_t issue_inst;
    pc_t   issue_pc;
    logic  issue_ack;
    logic  flags_vld, flag_eq, flag_gt;
    logic  blink_wr_en;
    pc_t   blink_wr_data, blink_rd_data;
    logic  queue_ready, emit_req, emit_ack;
    logic  busy;
`ifdef QS_UCODE_FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    inst_t rom [256];
    pc_t   link;
    int    passed = 0;
    int    total  = 0;
    inst_t mov_i;

    always #5 clk = ~clk;

    assign rin           = rom[ra];
    assign blink_rd_data = link;

    always @(posedge clk or posedge rst)
        if (rst) link <= '0;
        else if (blink_wr_en) link <= blink_wr_data;

    qs_ucode_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .ra            (ra),
        .rin           (rin),
        .issue_vld     (issue_vld),
        .issue_inst    (issue_inst),
        .issue_pc      (issue_pc),
        .issue_ack     (issue_ack),
        .flags_vld     (flags_vld),
        .flag_eq       (flag_eq),
        .flag_gt       (flag_gt),
        .blink_wr_en   (blink_wr_en),
        .blink_wr_data (blink_wr_data),
        .blink_rd_data (blink_rd_data),
        .queue_ready   (queue_ready),
        .emit_req      (emit_req),
        .emit_ack      (emit_ack),
`ifdef QS_UCODE_FETCH_PERF_EN
        .stall_cnt     (stall_cnt),
`endif
        .busy          (busy)
    );

    function automatic inst_t mk(input op_t op, input cc_t cc, input pc_t a);
        inst_t r;
        r.op  = op;
        r.cc  = cc;
        r.rsv = 2'b00;
        r.a   = a;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, CC_AL, 8'h00);
        mov_i       = mk(OP_MOV, CC_AL, 8'h30);
        rom[8'h00]  = mk(OP_J, CC_AL, 8'h20);
        rom[8'h20]  = mk(OP_WAIT, CC_AL, 8'h00);
        rom[8'h23]  = mk(OP_CALL, CC_AL, 8'h60);
        rom[8'h60]  = mk(OP_RET, CC_AL, 8'h00);
        rom[8'h24]  = mk(OP_EMIT, CC_AL, 8'h00);
        rom[8'h25]  = mk(OP_J, CC_AL, 8'h46);
        rom[8'h46]  = mov_i;
        rom[8'h48]  = inst_t'(16'hF0AA);
        rom[8'h4C]  = mk(OP_J, CC_GT, 8'h51);
        rom[8'h51]  = mk(OP_J, CC_EQ, 8'h70);
        rom[8'h52]  = mk(OP_J, CC_AL, 8'hFF);

        rst = 1'b1;
        issue_ack = 0; flags_vld = 0; flag_eq = 0; flag_gt = 0;
        queue_ready = 0; emit_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ra", ra, 8'h00);
        chk("rst_issue_vld", issue_vld, 0);
        chk("rst_emit_req", emit_req, 0);
        chk("rst_blink_wr_en", blink_wr_en, 0);
        chk("rst_busy", busy, 1);

        rst = 1'b0;
        chk("fetch0_ra", ra, 8'h00);
        chk("j_no_issue", issue_vld, 0);
        tick();
        chk("j20_ra", ra, 8'h20);
        chk("wait_run_busy", busy, 1);
        tick();
        chk("wait_busy0", busy, 0);
        chk("wait_hold_ra", ra, 8'h20);
        tick();
        chk("wait_hold_ra2", ra, 8'h20);
        queue_ready = 1;
        tick();
        queue_ready = 0;
        chk("wait_exit_ra", ra, 8'h21);
        chk("wait_exit_busy", busy, 1);
        tick();
        tick();
        chk("call_ra", ra, 8'h23);
        chk("call_wr_en", blink_wr_en, 1);
        chk("call_wr_data", blink_wr_data, 8'h24);
        tick();
        chk("call_tgt_ra", ra, 8'h60);
        chk("call_wr_pulse", blink_wr_en, 0);
        tick();
        chk("ret_ra", ra, 8'h24);

        chk("emit_run_req", emit_req, 0);
        emit_ack = 1;
        tick();
        emit_ack = 0;
        chk("emit_stray_ack", emit_req, 1);
        chk("emit_hold_ra", ra, 8'h24);
        tick();
        chk("emit_hold_req", emit_req, 1);
        emit_ack = 1;
        tick();
        emit_ack = 0;
        chk("emit_done_ra", ra, 8'h25);
        chk("emit_done_req", emit_req, 0);

        tick();
        chk("mov_ra", ra, 8'h46);
        chk("mov_vld", issue_vld, 1);
        chk("mov_inst", issue_inst, mov_i);
        chk("mov_pc", issue_pc, 8'h46);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_vld", issue_vld, 1);
            chk("bp_inst", issue_inst, mov_i);
            chk("bp_pc", issue_pc, 8'h46);
        end
        issue_ack = 1;
        tick();
        issue_ack = 0;
        chk("bp_adv_ra", ra, 8'h47);
        chk("nop_no_issue", issue_vld, 0);
        tick();
        chk("undef_ra", ra, 8'h48);
        chk("undef_vld", issue_vld, 0);
        chk("undef_wr_en", blink_wr_en, 0);
        chk("undef_emit", emit_req, 0);
        tick();
        chk("undef_adv_ra", ra, 8'h49);
        repeat (3) tick();
        chk("jgt_ra", ra, 8'h4C);
        chk("jgt_no_issue", issue_vld, 0);
        tick();
        chk("flags_stall1", ra, 8'h4C);
        tick();
        chk("flags_stall2", ra, 8'h4C);
        flags_vld = 1; flag_gt = 1; flag_eq = 0;
        tick();
        chk("jgt_taken_ra", ra, 8'h51);
        tick();
        chk("jeq_not_taken", ra, 8'h52);
        flags_vld = 0; flag_gt = 0;
        tick();
        chk("jff_ra", ra, 8'hFF);
        tick();
        chk("wrap_ra", ra, 8'h00);

        tick();
        tick();
        queue_ready = 1;
        tick();
        queue_ready = 0;
        chk("loop2_ra", ra, 8'h21);
        repeat (4) tick();
        chk("loop2_emit_ra", ra, 8'h24);
        tick();
        chk("loop2_emit_req", emit_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_emit_req", emit_req, 0);
        chk("arst_ra", ra, 8'h00);
        chk("arst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_ra", ra, 8'h00);
        tick();
        chk("rel_j20_ra", ra, 8'h20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
